// File: rtl/game_ctrl_if.sv
// Signal bundle between the dino-game sequencer and its neighbours:
// inputs from the synchroniser/collision detector, outputs to scroll and renderer.
interface game_ctrl_if;
    logic        btn;
    logic        collision;
    logic        frame_tick;
    logic        game_rst;
    logic        halt;
    logic [7:0]  speed_change;
    logic [7:0]  move_amt;
    logic [15:0] score;
    logic [15:0] hi_score;
    logic [2:0]  level;
    logic [1:0]  state;

    modport master (
        output btn, collision, frame_tick,
        input  game_rst, halt, speed_change, move_amt, score, hi_score, level, state
    );

    modport slave (
        input  btn, collision, frame_tick,
        output game_rst, halt, speed_change, move_amt, score, hi_score, level, state
    );
endinterface

// File: rtl/game_ctrl.sv
// Dino game sequencer: IDLE -> START (restart pulse) -> RUN (score/level) -> DEAD,
// driving scroll control and keeping BCD score / high score.
module game_ctrl #(
    parameter int RST_CYCLES   = 4,
    parameter int DEAD_HOLD    = 60,
    parameter int LEVEL_FRAMES = 600,
    parameter int MAX_LEVEL    = 7,
    parameter int BASE_MOVE    = 2,
    parameter int SPEED_STEP   = 8
) (
    input  logic        clk,
    input  logic        sys_rst,
    game_ctrl_if.slave  bus
);
    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int HW = $clog2(DEAD_HOLD + 1);
    localparam int LW = $clog2(LEVEL_FRAMES + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_DEAD  = 2'd3
    } state_t;

    state_t          state_q;
    logic            btn_q;
    logic            game_rst_q;
    logic            halt_q;
    logic [7:0]      speed_change_q;
    logic [7:0]      move_amt_q;
    logic [15:0]     score_q;
    logic [15:0]     hi_score_q;
    logic [2:0]      level_q;
    logic [RW-1:0]   rst_cnt_q;
    logic [HW-1:0]   hold_cnt_q;
    logic [LW-1:0]   lvl_cnt_q;

    logic            press;
    logic            hold_done;
    logic            start_req;
    logic            lvl_wrap;
    logic [15:0]     score_d;
    logic [2:0]      level_d;
    logic [7:0]      move_amt_d;
    logic [7:0]      speed_change_d;

    // Saturating 4-digit BCD increment with per-digit carry.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (r[4*i +: 4] == 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        press      = bus.btn & ~btn_q;
        hold_done  = (hold_cnt_q == HW'(DEAD_HOLD));
        start_req  = press & ((state_q == S_IDLE) | ((state_q == S_DEAD) & hold_done));
        lvl_wrap   = (lvl_cnt_q == LW'(LEVEL_FRAMES - 1));
        score_d    = bcd_inc(score_q);
        level_d    = (level_q == 3'(MAX_LEVEL)) ? level_q : level_q + 3'd1;
        // A new game forces level-0 difficulty for the whole START phase.
        move_amt_d     = 8'(BASE_MOVE) + (start_req ? 8'd0 : {5'd0, level_q});
        speed_change_d = (!start_req && (level_q == 3'(MAX_LEVEL))) ? 8'd0 : 8'(SPEED_STEP);
    end

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous, inside the clocked block.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_q        <= S_IDLE;
            btn_q          <= 1'b0;
            game_rst_q     <= 1'b0;
            halt_q         <= 1'b1;
            speed_change_q <= 8'(SPEED_STEP);
            move_amt_q     <= 8'(BASE_MOVE);
            score_q        <= 16'h0000;
            hi_score_q     <= 16'h0000;
            level_q        <= 3'd0;
            rst_cnt_q      <= '0;
            hold_cnt_q     <= '0;
            lvl_cnt_q      <= '0;
        end else begin
            btn_q          <= bus.btn;
            move_amt_q     <= move_amt_d;
            speed_change_q <= speed_change_d;
            if (start_req) begin
                state_q    <= S_START;
                game_rst_q <= 1'b1;
                halt_q     <= 1'b1;
                score_q    <= 16'h0000;
                level_q    <= 3'd0;
                lvl_cnt_q  <= '0;
                rst_cnt_q  <= '0;
                hold_cnt_q <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        halt_q <= 1'b1;
                    end
                    S_START: begin
                        if (rst_cnt_q == RW'(RST_CYCLES - 1)) begin
                            state_q    <= S_RUN;
                            game_rst_q <= 1'b0;
                            halt_q     <= 1'b0;
                        end else begin
                            rst_cnt_q <= rst_cnt_q + 1'b1;
                        end
                    end
                    S_RUN: begin
                        // Collision outranks a same-cycle frame_tick, which goes unscored.
                        if (bus.collision) begin
                            state_q    <= S_DEAD;
                            halt_q     <= 1'b1;
                            hold_cnt_q <= '0;
                            if (score_q > hi_score_q) hi_score_q <= score_q;
                        end else if (bus.frame_tick) begin
                            score_q <= score_d;
                            if (lvl_wrap) begin
                                lvl_cnt_q <= '0;
                                level_q   <= level_d;
                            end else begin
                                lvl_cnt_q <= lvl_cnt_q + 1'b1;
                            end
                        end
                    end
                    S_DEAD: begin
                        if (bus.frame_tick && !hold_done) hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.game_rst     = game_rst_q;
    assign bus.halt         = halt_q;
    assign bus.speed_change = speed_change_q;
    assign bus.move_amt     = move_amt_q;
    assign bus.score        = score_q;
    assign bus.hi_score     = hi_score_q;
    assign bus.level        = level_q;
    assign bus.state        = state_q;
endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: integer-level game model compared every cycle,
// plus directed checks with hand-computed literals.
module tb_game_ctrl;
    localparam int RST_CYCLES   = 4;
    localparam int DEAD_HOLD    = 60;
    localparam int LEVEL_FRAMES = 3;
    localparam int MAX_LEVEL    = 7;
    localparam int BASE_MOVE    = 2;
    localparam int SPEED_STEP   = 8;

    logic clk = 1'b0;
    logic sys_rst;
    int   total = 0;
    int   bad   = 0;

    game_ctrl_if bus ();

    game_ctrl #(
        .RST_CYCLES  (RST_CYCLES),
        .DEAD_HOLD   (DEAD_HOLD),
        .LEVEL_FRAMES(LEVEL_FRAMES),
        .MAX_LEVEL   (MAX_LEVEL),
        .BASE_MOVE   (BASE_MOVE),
        .SPEED_STEP  (SPEED_STEP)
    ) dut (
        .clk    (clk),
        .sys_rst(sys_rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // Game model: score as a plain integer, level derived from ticks played this game.
    bit m_valid = 0;
    int m_st, m_score, m_hi, m_ticks, m_lvl, m_move, m_speed, m_start_cnt, m_hold;
    bit m_btn_prev, m_grst, m_halt;

    always @(posedge clk) begin
        int lvl_old;
        bit press, enter;
        if (sys_rst) begin
            m_valid = 1; m_st = 0; m_btn_prev = 0; m_score = 0; m_hi = 0; m_ticks = 0;
            m_lvl = 0; m_move = BASE_MOVE; m_speed = SPEED_STEP; m_grst = 0; m_halt = 1;
            m_start_cnt = 0; m_hold = 0;
        end else if (m_valid) begin
            press   = bus.btn && !m_btn_prev;
            lvl_old = m_lvl;
            enter   = 0;
            case (m_st)
                0: enter = press;
                1: if (m_start_cnt == RST_CYCLES) begin
                       m_st = 2; m_grst = 0; m_halt = 0;
                   end else m_start_cnt++;
                2: if (bus.collision) begin
                       m_st = 3; m_halt = 1; m_hold = 0;
                       if (m_score > m_hi) m_hi = m_score;
                   end else if (bus.frame_tick) begin
                       m_score = (m_score < 9999) ? m_score + 1 : 9999;
                       m_ticks++;
                       m_lvl = (m_ticks / LEVEL_FRAMES > MAX_LEVEL) ? MAX_LEVEL : m_ticks / LEVEL_FRAMES;
                   end
                default: if (press && m_hold >= DEAD_HOLD) enter = 1;
                         else if (bus.frame_tick && m_hold < DEAD_HOLD) m_hold++;
            endcase
            if (enter) begin
                m_st = 1; m_start_cnt = 1; m_grst = 1; m_halt = 1;
                m_score = 0; m_ticks = 0; m_lvl = 0; lvl_old = 0;
            end
            m_move  = BASE_MOVE + lvl_old;
            m_speed = (lvl_old < MAX_LEVEL) ? SPEED_STEP : 0;
            m_btn_prev = bus.btn;
        end
        #1;
        if (m_valid) begin
            check("cyc_state",    32'(bus.state),        32'(m_st));
            check("cyc_game_rst", 32'(bus.game_rst),     32'(m_grst));
            check("cyc_halt",     32'(bus.halt),         32'(m_halt));
            check("cyc_score",    32'(bus.score),        32'(to_bcd(m_score)));
            check("cyc_hi_score", 32'(bus.hi_score),     32'(to_bcd(m_hi)));
            check("cyc_level",    32'(bus.level),        32'(m_lvl));
            check("cyc_move_amt", 32'(bus.move_amt),     32'(m_move));
            check("cyc_speed",    32'(bus.speed_change), 32'(m_speed));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            @(negedge clk) bus.frame_tick = 1'b1;
            @(negedge clk) bus.frame_tick = 1'b0;
        end
    endtask

    task automatic press_once();
        @(negedge clk) bus.btn = 1'b1;
        @(negedge clk) bus.btn = 1'b0;
    endtask

    initial begin
        int starts, grst_cycles;
        logic [1:0] prev_state;
        sys_rst = 1'b1;
        bus.btn = 1'b0;
        bus.collision = 1'b0;
        bus.frame_tick = 1'b0;

        // Reset values
        idle(2);
        check("rst_state",    32'(bus.state),        32'd0);
        check("rst_halt",     32'(bus.halt),         32'd1);
        check("rst_game_rst", 32'(bus.game_rst),     32'd0);
        check("rst_move_amt", 32'(bus.move_amt),     32'd2);
        check("rst_speed",    32'(bus.speed_change), 32'd8);
        check("rst_score",    32'(bus.score),        32'h0);
        sys_rst = 1'b0;

        // Held button: one START, four game_rst cycles, then RUN
        starts = 0; grst_cycles = 0; prev_state = bus.state;
        bus.btn = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (bus.state == 2'd1 && prev_state != 2'd1) starts++;
            if (bus.game_rst) grst_cycles++;
            prev_state = bus.state;
        end
        bus.btn = 1'b0;
        check("hold_starts",     32'(starts),      32'd1);
        check("hold_grst_count", 32'(grst_cycles), 32'd4);
        check("run_state",       32'(bus.state),   32'd2);
        check("run_halt",        32'(bus.halt),    32'd0);

        // Level stepping with LEVEL_FRAMES=3
        tick_n(18);
        check("lvl6_level", 32'(bus.level), 32'd6);
        idle(1);
        check("lvl6_move",  32'(bus.move_amt), 32'd8);
        tick_n(3);
        check("lvl7_level",      32'(bus.level),        32'd7);
        check("lvl7_speed_lag",  32'(bus.speed_change), 32'd8);
        idle(1);
        check("lvl7_speed",      32'(bus.speed_change), 32'd0);
        check("lvl7_move",       32'(bus.move_amt),     32'd9);
        tick_n(9);
        check("lvl_hold_level",  32'(bus.level),        32'd7);
        check("score_30",        32'(bus.score),        32'h0030);

        // BCD scoring and saturation
        tick_n(1204);
        check("score_1234", 32'(bus.score), 32'h1234);
        tick_n(8770);
        check("score_sat",  32'(bus.score), 32'h9999);

        // Collision with same-cycle press and tick
        @(negedge clk) begin bus.btn = 1'b1; bus.collision = 1'b1; bus.frame_tick = 1'b1; end
        @(negedge clk) begin bus.btn = 1'b0; bus.collision = 1'b0; bus.frame_tick = 1'b0; end
        check("dead_state", 32'(bus.state),    32'd3);
        check("dead_halt",  32'(bus.halt),     32'd1);
        check("dead_hi",    32'(bus.hi_score), 32'h9999);
        tick_n(10);
        press_once();
        check("early_press_ignored", 32'(bus.state), 32'd3);
        tick_n(50);
        press_once();
        check("restart_state", 32'(bus.state),    32'd1);
        check("restart_grst",  32'(bus.game_rst), 32'd1);
        check("restart_score", 32'(bus.score),    32'h0);

        // Lower second game keeps the high score
        idle(6);
        tick_n(5);
        @(negedge clk) begin bus.btn = 1'b1; bus.collision = 1'b1; bus.frame_tick = 1'b1; end
        @(negedge clk) begin bus.btn = 1'b0; bus.collision = 1'b0; bus.frame_tick = 1'b0; end
        check("g2_state", 32'(bus.state),    32'd3);
        check("g2_score", 32'(bus.score),    32'h0005);
        check("g2_hi",    32'(bus.hi_score), 32'h9999);

        // sys_rst in RUN
        tick_n(60);
        press_once();
        idle(6);
        tick_n(3);
        check("g3_run", 32'(bus.state), 32'd2);
        @(negedge clk) sys_rst = 1'b1;
        @(negedge clk);
        check("srst_state", 32'(bus.state),    32'd0);
        check("srst_hi",    32'(bus.hi_score), 32'h0);
        check("srst_halt",  32'(bus.halt),     32'd1);
        check("srst_grst",  32'(bus.game_rst), 32'd0);
        sys_rst = 1'b0;
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
